// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction fetch queue.
package inst_fetch_queue_pkg;

   localparam int          DEFAULT_DEPTH = 4;
   localparam logic [31:0] DEFAULT_NOP   = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Storage array for the fetch queue: clocked write port, asynchronous read port.
module fetch_queue_mem
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEFAULT_DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [63:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [63:0]   o_rdata
);

   // Contents are never reset; occupancy tracking in the parent decides what is valid.
   logic [63:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular fetch queue between instruction memory and decode, with flush and sticky overflow.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int          DEPTH = DEFAULT_DEPTH,
   parameter logic [31:0] NOP   = DEFAULT_NOP
) (
   input  logic                     CLK,
   input  logic                     NRST,
   input  logic                     in_valid,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_inst,
   output logic                     full,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   input  logic                     flush,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic          w_push;
   logic          w_pop;
   logic          w_we;
   logic [63:0]   w_rdata;
   fq_entry_t     w_wrEntry;
   fq_entry_t     w_head;

   assign out_valid = (r_count != '0);
   assign full      = (r_count == FULL_CNT);
   assign count     = r_count;
   assign overflow  = r_overflow;

   // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
   assign w_pop  = out_valid & out_ready;
   assign w_push = in_valid & (~full | w_pop);
   assign w_we   = w_push & NRST & ~flush;

   assign w_wrEntry.pc   = in_pc;
   assign w_wrEntry.inst = in_inst;
   assign w_head         = fq_entry_t'(w_rdata);

   assign out_pc   = out_valid ? w_head.pc   : 32'h0;
   assign out_inst = out_valid ? w_head.inst : NOP;

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (CLK),
      .i_we    (w_we),
      .i_waddr (r_wrPtr),
      .i_wdata (w_wrEntry),
      .i_raddr (r_rdPtr),
      .o_rdata (w_rdata)
   );

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (in_valid & full & ~w_pop) begin
            r_overflow <= 1'b1;
         end
         if (flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
               r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push & ~w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (w_pop & ~w_push) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH SHALL be 4 by default: number of queue entries, a power of two, at least 2.
REQ-002 Parameter NOP SHALL be 32'h00000013 by default: instruction presented when the queue is empty.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port NRST, input, 1 bit, SHALL be the reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit, SHALL mark that a fetched {in_pc, in_inst} pair is offered this cycle.
REQ-006 Port in_pc, input, 32 bits, SHALL carry the PC of the offered instruction.
REQ-007 Port in_inst, input, 32 bits, SHALL carry the instruction word read from instruction memory.
REQ-008 Port full, output, 1 bit, SHALL be the stall request to the PC register.
REQ-009 Port out_valid, output, 1 bit, SHALL mark that the head entry is presented to decode.
REQ-010 Port out_ready, input, 1 bit, SHALL mark that decode accepts the head entry this cycle.
REQ-011 Port out_pc, output, 32 bits, SHALL carry the head-entry PC.
REQ-012 Port out_inst, output, 32 bits, SHALL carry the head-entry instruction.
REQ-013 Port flush, input, 1 bit, SHALL be the redirect from a taken branch or jump that discards all entries.
REQ-014 Port overflow, output, 1 bit, SHALL be a sticky flag raised when an offered entry is dropped.
REQ-015 Port count, output, log2(DEPTH)+1 bits, SHALL give the current occupancy.

Function
REQ-016 The queue SHALL be a circular buffer of DEPTH {pc, inst} entries with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 Define push = in_valid & (!full | pop), pop = out_valid & out_ready, and act on both only at the rising edge.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 full SHALL equal (count == DEPTH).
REQ-020 out_pc and out_inst SHALL be read combinationally from the entry at the read pointer.
REQ-021 When the queue is empty, out_pc SHALL be 0 and out_inst SHALL be NOP.
REQ-022 Latency SHALL be one cycle: an entry pushed at edge N is presented at out_* after edge N when the queue was empty.
REQ-023 Push without pop SHALL increment count; pop without push SHALL decrement count; push with pop SHALL leave count unchanged and advance both pointers.
REQ-024 Push and pop in the same cycle while full SHALL be accepted.
REQ-025 Push and pop in the same cycle while empty SHALL NOT occur, because out_valid is 0 and there is no fall-through.
REQ-026 When in_valid & full & !pop, the entry SHALL be dropped, the queue SHALL be unchanged, and overflow SHALL be set to 1 until reset.
REQ-027 flush SHALL, at the edge, set count and both pointers to 0 and ignore any simultaneous push or pop.
REQ-028 After a flush, out_valid SHALL be 0 in the following cycle.
REQ-029 Entries SHALL leave the queue in push order.
REQ-030 PC values SHALL pass through unmodified, with no alignment check.

Reset
REQ-031 While NRST=0 at an edge, the block SHALL clear count, both pointers and overflow.
REQ-032 After reset, outputs SHALL be: out_valid=0, full=0, count=0, out_pc=0, out_inst=NOP.
REQ-033 Reset SHALL take priority over flush, push and pop; reset mid-operation SHALL discard all entries.
REQ-034 Storage array contents SHALL NOT need a reset.

Structure
REQ-035 NOP and the default DEPTH SHALL live in define.vh alongside the existing constants.
REQ-036 The storage array SHALL be a sub-module named fetch_queue_mem: write port on the rising edge, asynchronous read.
REQ-037 Pointer, count and flag logic SHALL reside in inst_fetch_queue.

Verification
REQ-038 Reset then idle: out_valid=0, out_inst=32'h00000013, count=0, full=0.
REQ-039 Push pc 0x8000, 0x8004, 0x8008 with out_ready=0, then hold out_ready=1: outputs appear in order, one per cycle, and count steps 3,2,1,0.
REQ-040 Fill 4 entries, then in_valid=1 with out_ready=0: the entry is dropped, overflow=1, and the head is still 0x8000.
REQ-041 Full queue with in_valid=1 and out_ready=1 each cycle for 8 cycles: count holds at 4, pointers wrap twice, and no loss occurs.
REQ-042 3 entries, then flush=1 with in_valid=1 the same cycle: next cycle count=0, out_valid=0, and the pushed entry is absent.
REQ-043 NRST=0 asserted with 2 entries and overflow=1: after the edge, count=0, overflow=0, out_valid=0.
